// File: rtl/program_memory_loadable.sv
// Loadable program memory: swept to FILL_WORD after reset, written at runtime
// through a valid/ready byte-load port, and fetched by the CPU while in RUN.
module program_memory_loadable #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD    = 8'b0111_0000,
  parameter int                    READ_LATENCY = 0
) (
  input  logic                  program_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_bus,
  output logic [DATA_WIDTH-1:0] data_bus,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  load_end,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_wrapped,
  output logic                  busy
);

  localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
  logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
  logic                  load_wrapped_q, load_wrapped_d;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  always_comb begin
    state_d        = state_q;
    fill_addr_d    = fill_addr_q;
    load_addr_d    = load_addr_q;
    load_count_d   = load_count_q;
    load_wrapped_d = load_wrapped_q;
    wr_en          = 1'b0;
    wr_addr        = fill_addr_q;
    wr_data        = FILL_WORD;
    case (state_q)
      ST_FILL: begin
        wr_en       = 1'b1;
        fill_addr_d = fill_addr_q + 1'b1;
        if (fill_addr_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (load_start) begin
          state_d        = ST_LOAD;
          load_addr_d    = load_base;
          load_count_d   = '0;
          load_wrapped_d = 1'b0;
        end
      end
      ST_LOAD: begin
        // The word accompanying load_end is still written before leaving LOAD.
        if (load_valid) begin
          wr_en        = 1'b1;
          wr_addr      = load_addr_q;
          wr_data      = load_data;
          load_count_d = (load_count_q == COUNT_MAX) ? load_count_q : load_count_q + 1'b1;
          if (load_addr_q == LAST_ADDR) begin
            state_d        = ST_RUN;
            load_wrapped_d = 1'b1;
          end else begin
            load_addr_d = load_addr_q + 1'b1;
          end
        end
        if (load_end) state_d = ST_RUN;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge program_clk) begin
    if (!reset) begin
      state_q        <= ST_FILL;
      fill_addr_q    <= '0;
      load_addr_q    <= '0;
      load_count_q   <= '0;
      load_wrapped_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_addr_q    <= fill_addr_d;
      load_addr_q    <= load_addr_d;
      load_count_q   <= load_count_d;
      load_wrapped_q <= load_wrapped_d;
    end
  end

  always_ff @(posedge program_clk) begin
    if (reset && wr_en) mem[wr_addr] <= wr_data;
  end

  assign busy         = (state_q != ST_RUN);
  assign load_ready   = (state_q == ST_LOAD);
  assign load_count   = load_count_q;
  assign load_wrapped = load_wrapped_q;

  // The CPU only ever sees RAM contents in RUN, so no read-during-write case exists.
  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign data_bus = (state_q == ST_RUN) ? mem[address_bus] : FILL_WORD;
    end else if (READ_LATENCY == 1) begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_data_q;
      always_ff @(posedge program_clk) begin
        if (!reset) rd_data_q <= FILL_WORD;
        else        rd_data_q <= (state_q == ST_RUN) ? mem[address_bus] : FILL_WORD;
      end
      assign data_bus = rd_data_q;
    end else begin : g_bad_latency
      $error("program_memory_loadable: READ_LATENCY must be 0 or 1");
    end
  endgenerate

endmodule

// File: tb/tb_program_memory_loadable.sv
// Randomised bench for program_memory_loadable: one combinational-read and one
// registered-read instance share stimulus and are checked against a word-level model.
module tb_program_memory_loadable;

  logic       program_clk = 1'b0;
  logic       reset;
  logic [7:0] address_bus, load_base, load_data;
  logic       load_start, load_valid, load_end;
  logic [7:0] data0, data1;
  logic       ready0, ready1, wrap0, wrap1, busy0, busy1;
  logic [8:0] cnt0, cnt1;

  always #5 program_clk = ~program_clk;

  program_memory_loadable #(.READ_LATENCY(0)) u_dut0 (
    .program_clk(program_clk), .reset(reset), .address_bus(address_bus), .data_bus(data0),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_ready(ready0), .load_end(load_end),
    .load_count(cnt0), .load_wrapped(wrap0), .busy(busy0));

  program_memory_loadable #(.READ_LATENCY(1)) u_dut1 (
    .program_clk(program_clk), .reset(reset), .address_bus(address_bus), .data_bus(data1),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_ready(ready1), .load_end(load_end),
    .load_count(cnt1), .load_wrapped(wrap1), .busy(busy1));

  int         tests = 0;
  int         fails = 0;
  logic [7:0] model_mem [256];
  int         m_count;
  bit         m_wrapped;
  int         m_next;
  logic [7:0] wq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge program_clk);
    @(negedge program_clk);
  endtask

  task automatic check_status(input string tag, input bit exp_busy, input bit exp_ready);
    check({tag, ".busy0"}, busy0, exp_busy);
    check({tag, ".busy1"}, busy1, exp_busy);
    check({tag, ".ready0"}, ready0, exp_ready);
    check({tag, ".ready1"}, ready1, exp_ready);
    check({tag, ".count0"}, cnt0, m_count);
    check({tag, ".count1"}, cnt1, m_count);
    check({tag, ".wrapped0"}, wrap0, m_wrapped);
    check({tag, ".wrapped1"}, wrap1, m_wrapped);
  endtask

  // Latency 0 answers in the same cycle; latency 1 after the next edge.
  task automatic read_check(input logic [7:0] a);
    address_bus = a;
    #1;
    check($sformatf("rd0[%0h]", a), data0, model_mem[a]);
    step();
    check($sformatf("rd1[%0h]", a), data1, model_mem[a]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    m_count   = 0;
    m_wrapped = 0;
    check_status("reset", 1'b1, 1'b0);
    check("reset.data0", data0, 8'h70);
    check("reset.data1", data1, 8'h70);
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h70;
    reset = 1'b1;
  endtask

  task automatic run_fill(input int pulse_at);
    int n        = 0;
    int fill_bad = 0;
    while (busy0 === 1'b1 && n < 400) begin
      address_bus = 8'($urandom);
      #1;
      if (data0 !== 8'h70) fill_bad++;
      if (data1 !== 8'h70) fill_bad++;
      load_start = (n == pulse_at);
      load_base  = 8'h33;
      step();
      n++;
    end
    load_start = 1'b0;
    check("fill_cycles", n, 256);
    check("fill_data", fill_bad, 0);
    check_status("after_fill", 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [7:0] base, input bit gaps, input bit end_together);
    int addr    = base;
    bit in_load = 1'b1;
    load_start = 1'b1;
    load_base  = base;
    step();
    load_start = 1'b0;
    m_count    = 0;
    m_wrapped  = 0;
    check_status("start", 1'b1, 1'b1);
    for (int i = 0; i < wq.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          step();
          check("gap_ready", ready0, in_load);
        end
      end
      check("pre_ready", ready0, in_load);
      load_valid = 1'b1;
      load_data  = wq[i];
      load_end   = end_together && (i == wq.size() - 1);
      step();
      if (in_load) begin
        model_mem[addr] = wq[i];
        m_count++;
        if (addr == 255) begin
          in_load   = 1'b0;
          m_wrapped = 1'b1;
        end else begin
          addr++;
        end
        if (load_end) in_load = 1'b0;
      end
      load_valid = 1'b0;
      load_end   = 1'b0;
    end
    if (in_load) begin
      load_end = 1'b1;
      step();
      load_end = 1'b0;
    end
    m_next = addr;
    check_status("end", 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; address_bus = '0; load_base = '0; load_data = '0;
    load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0;
    m_count = 0; m_wrapped = 0; m_next = 0;
    @(negedge program_clk);

    do_reset();
    run_fill(-1);
    for (int a = 0; a < 256; a++) read_check(8'(a));

    wq = '{8'h81, 8'h05, 8'h2A};
    do_load(8'h10, 1'b1, 1'b0);
    check("basic_count", cnt0, 3);
    for (int a = 16; a < 19; a++) read_check(8'(a));

    wq = '{8'($urandom), 8'($urandom), 8'($urandom)};
    do_load(8'hFE, 1'b0, 1'b0);
    check("wrap_count", cnt0, 2);
    check("wrap_flag", wrap0, 1);
    read_check(8'hFE);
    read_check(8'hFF);
    read_check(8'h00);

    wq = '{8'hC3};
    do_load(8'h20, 1'b0, 1'b1);
    read_check(8'h20);

    // Stray load_valid in RUN must not touch memory or the count.
    wq = '{8'h11, 8'h22};
    do_load(8'h50, 1'b0, 1'b0);
    load_valid = 1'b1;
    repeat (4) begin
      load_data = 8'($urandom);
      step();
    end
    load_valid = 1'b0;
    check_status("stray_valid", 1'b0, 1'b0);
    read_check(8'(m_next));

    repeat (25) begin
      logic [7:0] base;
      int         n;
      n = $urandom_range(1, 8);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
      base = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom);
      do_load(base, 1'b1, 1'($urandom_range(0, 1)));
      read_check(base);
      repeat (3) read_check(8'($urandom));
    end

    // Reset in the middle of a load, with a load_start pulse during the fill.
    load_start = 1'b1;
    load_base  = 8'h40;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hA5;
    step();
    load_data  = 8'h5A;
    step();
    load_valid = 1'b0;
    do_reset();
    run_fill(10);
    read_check(8'h40);
    read_check(8'h41);
    repeat (4) read_check(8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/program_memory_loadable.md
Name: program_memory_loadable

Overview:
- Parametrised successor to the fixed 256x8 program ROM.
- Holds the CPU program in an inferred RAM. After reset it is swept to a fill word (NOP) one entry per cycle.
- A valid/ready byte-load port lets a host (UART bridge, test bench) write a program at runtime.
- The CPU fetch port supports combinational or registered read. The CPU sees the fill word whenever memory is not in RUN.

Parameters:
- DATA_WIDTH, 8, instruction word width.
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH.
- FILL_WORD, 8'b0111_0000, NOP encoding written on fill and driven while not RUN.
- READ_LATENCY, 0, fetch latency: 0 = combinational, 1 = registered. Other values are illegal; flagged by an elaboration check.

Ports:
- program_clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- address_bus  in  ADDR_WIDTH  CPU fetch address.
- data_bus  out  DATA_WIDTH  CPU fetch data.
- load_start  in  1  pulse; enter LOAD at load_base.
- load_base  in  ADDR_WIDTH  first write address, sampled with load_start.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_WIDTH  word to write.
- load_ready  out  1  high only in LOAD.
- load_end  in  1  pulse; finish LOAD.
- load_count  out  ADDR_WIDTH+1  words written in the current/last load.
- load_wrapped  out  1  sticky: last load hit address DEPTH-1 and auto-terminated.
- busy  out  1  high in FILL or LOAD; the CPU must be held while high.

Behaviour:
- Reset is sampled on a program_clk edge while reset==0. It sets:
  - state=FILL, fill_addr=0;
  - load_count=0, load_wrapped=0, load_ready=0, busy=1;
  - registered data_bus=FILL_WORD.
- Reset mid-LOAD aborts the load: words already written are discarded by the new fill.
- States and transitions:
  - FILL: each cycle with reset high, write mem[fill_addr]=FILL_WORD and increment fill_addr. The cycle writing DEPTH-1 moves to RUN. busy is therefore high for exactly DEPTH cycles after reset release.
  - RUN: busy=0, load_ready=0. load_start moves to LOAD and captures load_addr=load_base. load_count is cleared to 0 and load_wrapped to 0 on that same edge.
  - LOAD: load_ready=1, busy=1. Each cycle with load_valid=1:
    - write mem[load_addr]=load_data;
    - increment load_addr and load_count.
- LOAD exits:
  - load_end moves to RUN. If load_valid is also high that cycle, the word is written first, then the state exits.
  - Writing address DEPTH-1 auto-terminates: the state moves to RUN and load_wrapped is set. load_addr never wraps to 0.
- Ignored inputs:
  - load_start in FILL or LOAD is ignored.
  - load_valid/load_end outside LOAD are ignored; no writes occur.
- Fetch data:
  - In RUN: mem[address_bus].
  - Otherwise: FILL_WORD.
- Fetch latency:
  - READ_LATENCY=0: data_bus is combinational on address_bus and state.
  - READ_LATENCY=1: data_bus is registered; the value appears the cycle after the address.
- Read-during-write: not possible to the CPU, since the CPU sees FILL_WORD while not RUN.
- Widths: load_count saturates at DEPTH (ADDR_WIDTH+1 bits). Its max value is DEPTH only when load_base=0 and the load runs to the wrap.

Test Plan:
1. Reset fill: reset low for 2 cycles, then high; sample busy and data_bus across the sweep; read addr 0..255 after busy falls.
   - busy=1 for exactly 256 cycles, then 0.
   - data_bus=8'h70 throughout the fill.
   - Every address then reads 8'h70.
2. Basic load: load_start with load_base=8'h10; write 8'h81,8'h05,8'h2A with load_valid gaps; then load_end.
   - mem[0x10..0x12] hold these words.
   - load_count=3, load_wrapped=0.
   - In RUN, address 0x11 gives 8'h05 (same cycle at latency 0, next cycle at latency 1).
3. Wrap: load_base=8'hFE; 3 valid words.
   - 2 words are written; mem[0xFF] holds word 2.
   - load_count=2, load_wrapped=1, state RUN.
   - Word 3 is not written (load_ready=0); mem[0x00] remains 8'h70.
4. Simultaneous: load_valid=1 with load_end=1 at address 0x20, data 8'hC3.
   - mem[0x20]=8'hC3; state RUN the next cycle.
5. Reset mid-load: assert reset after 2 words at base 0x40.
   - Fill restarts with busy=1 for 256 cycles.
   - mem[0x40]=8'h70 afterwards; load_count=0.
6. Ignored inputs:
   - load_start during FILL: no LOAD is entered.
   - load_valid in RUN: no write occurs and load_count is unchanged.
